// File: rtl/apb_slave_regs.sv
// apb_slave_regs
//   APB register-bank slave downstream of the AHB-to-APB bridge. It latches the
//   setup phase and inserts WAIT_STATES access cycles. On completion it commits
//   a write or returns a read from NUM_REGS 32-bit registers. The index just
//   above the registers holds a read-only STATUS word, {read_count, write_count}.
//   Out-of-range accesses and writes to STATUS complete with PSLVERR.
//
// Parameters
//   NUM_REGS     number of read/write registers (1..62)
//   WAIT_STATES  access cycles before PREADY (0..15)
// Ports
//   HCLK     in   system clock, rising edge
//   HRST     in   asynchronous active-high reset
//   PSEL     in   slave select
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   [7:0] byte offset, word index = PADDR[7:2]
//   PWDATA   in   [31:0] write data
//   PRDATA   out  [31:0] read data, non-zero only while PREADY on a read
//   PREADY   out  transfer complete
//   PSLVERR  out  error response, only while PREADY
module apb_slave_regs #(
  parameter int NUM_REGS    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRST,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int          IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0]  STATUS_IDX = 6'(NUM_REGS);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   rd_cnt_q, rd_cnt_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d;
  logic [31:0]   regs_q [NUM_REGS];
  logic [31:0]   regs_d [NUM_REGS];

  logic          is_reg;
  logic          is_status;
  logic          err;
  logic          complete;
  logic [IW-1:0] ridx;

  // Byte-lane bits of the address carry no meaning for a word-only bank.
  logic unused_addr_bits;
  assign unused_addr_bits = ^PADDR[1:0];

  // Decode of the latched transfer; everything here depends only on flops, so
  // the outputs clear the moment HRST clears the state.
  assign ridx      = idx_q[IW-1:0];
  assign is_reg    = (idx_q < STATUS_IDX);
  assign is_status = (idx_q == STATUS_IDX);
  assign err       = !is_reg && !(is_status && !wr_q);
  assign PREADY    = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign complete  = PREADY && PSEL && PENABLE;
  assign PSLVERR   = PREADY && err;

  always_comb begin
    PRDATA = 32'h0;
    if (PREADY && !wr_q) begin
      if (is_reg)         PRDATA = regs_q[ridx];
      else if (is_status) PRDATA = {rd_cnt_q, wr_cnt_q};
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    regs_d   = regs_q;

    unique case (state_q)
      IDLE: begin
        // A lone PENABLE without a setup phase is not a transfer.
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          idx_d   = PADDR[7:2];
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (!PSEL) begin
          // Aborted by the master: nothing commits, nothing is counted.
          state_d = IDLE;
        end else if (complete) begin
          state_d = IDLE;
          // Error transfers are counted like any other completion.
          if (wr_q) wr_cnt_d = wr_cnt_q + 16'd1;
          else      rd_cnt_d = rd_cnt_q + 16'd1;
          if (wr_q && is_reg) regs_d[ridx] = wdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      // NOTE: the register file has a defined reset value, so it is built
      // from resettable flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      regs_q   <= regs_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Testbench for apb_slave_regs. Three instances (WAIT_STATES 0, 2 and 3) share
// the bus and are selected one at a time. Each transfer pushes its expected
// response into a queue. A monitor pops the queue on every completing access
// cycle and compares PRDATA and PSLVERR.
module tb_apb_slave_regs;

  logic        clk = 1'b0;
  logic        hrst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  int          sel;

  logic [31:0] prdata0, prdata1, prdata2, prdata_m;
  logic        pready0, pready1, pready2, pready_m;
  logic        pslverr0, pslverr1, pslverr2, pslverr_m;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  apb_slave_regs #(.NUM_REGS(4), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRST(hrst), .PSEL(psel && sel == 0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

  apb_slave_regs #(.NUM_REGS(4), .WAIT_STATES(2)) dut1 (
    .HCLK(clk), .HRST(hrst), .PSEL(psel && sel == 1), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1));

  apb_slave_regs #(.NUM_REGS(4), .WAIT_STATES(3)) dut2 (
    .HCLK(clk), .HRST(hrst), .PSEL(psel && sel == 2), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2));

  always_comb begin
    prdata_m  = prdata0;
    pready_m  = pready0;
    pslverr_m = pslverr0;
    case (sel)
      1: begin prdata_m = prdata1; pready_m = pready1; pslverr_m = pslverr1; end
      2: begin prdata_m = prdata2; pready_m = pready2; pslverr_m = pslverr2; end
      default: ;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every completing access cycle consumes one expected response.
  always @(negedge clk) begin
    if (!hrst && pready_m && psel && penable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_rdata"}, prdata_m, e.rdata);
        check({e.name, "_slverr"}, {31'd0, pslverr_m}, {31'd0, e.err});
      end
    end
  end

  // One full transfer on instance k. Entered and left at posedge+1. The
  // address, data and direction are scrambled during the access phase to show
  // that the slave uses its latched copies.
  task automatic xfer(input int k, input bit w, input logic [7:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd,
                      input bit exp_err, input int exp_waits, input string nm);
    exp_t e;
    int   waits;
    bit   got;
    e.name = nm; e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    sel = k; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1; pwrite = ~w; paddr = 8'hFF; pwdata = ~d;
    waits = 0; got = 1'b0;
    for (int c = 0; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (pready_m) got = 1'b1;
      else          waits++;
      @(posedge clk); #1;
    end
    check({nm, "_ready"}, {31'd0, got}, 32'd1);
    check({nm, "_waits"}, waits, exp_waits);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hrst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sel = k; #1;
      check("reset_pready", {31'd0, pready_m}, 32'd0);
      check("reset_prdata", prdata_m, 32'd0);
      check("reset_pslverr", {31'd0, pslverr_m}, 32'd0);
    end
    @(posedge clk); #1;
    hrst = 1'b0;
    @(posedge clk); #1;

    // Instance 0, no wait states: basic access, byte bits, errors.
    xfer(0, 1, 8'h0C, 32'hAAAAAAAA, 32'h0,        0, 0, "w0_wr_0c");
    xfer(0, 0, 8'h0C, 32'h0,        32'hAAAAAAAA, 0, 0, "w0_rd_0c");
    xfer(0, 0, 8'h0F, 32'h0,        32'hAAAAAAAA, 0, 0, "w0_rd_0f");
    xfer(0, 1, 8'h14, 32'h12345678, 32'h0,        1, 0, "w0_wr_oob");
    xfer(0, 0, 8'h14, 32'h0,        32'h0,        1, 0, "w0_rd_oob");
    xfer(0, 1, 8'h10, 32'hFFFFFFFF, 32'h0,        1, 0, "w0_wr_status");
    xfer(0, 0, 8'h0C, 32'h0,        32'hAAAAAAAA, 0, 0, "w0_rd_0c_after_err");
    xfer(0, 0, 8'h04, 32'h0,        32'h0,        0, 0, "w0_rd_04_untouched");

    // PENABLE in IDLE without a setup phase must not start a transfer.
    sel = 0; psel = 1'b1; penable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("penable_only_pready", {31'd0, pready_m}, 32'd0);
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    xfer(0, 0, 8'h0C, 32'h0, 32'hAAAAAAAA, 0, 0, "w0_rd_after_penable");
    // 6 reads and 3 writes so far, the errored ones included.
    xfer(0, 0, 8'h10, 32'h0, 32'h00060003, 0, 0, "w0_status");

    // Instance 1, two wait states: readback, abort, counters.
    xfer(1, 1, 8'h04, 32'hBBBBBBBB, 32'h0,        0, 2, "w2_wr_04");
    xfer(1, 0, 8'h04, 32'h0,        32'hBBBBBBBB, 0, 2, "w2_rd_04");
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h00; pwdata = 32'hCCCCCCCC;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("abort_pready", {31'd0, pready_m}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    xfer(1, 0, 8'h00, 32'h0, 32'h0, 0, 2, "w2_rd_00_after_abort");
    xfer(1, 1, 8'h08, 32'h00000002, 32'h0, 0, 2, "w2_wr_08");
    xfer(1, 1, 8'h0C, 32'h00000003, 32'h0, 0, 2, "w2_wr_0c");
    xfer(1, 0, 8'h10, 32'h0, 32'h00020003, 0, 2, "w2_status");

    // Preload the write count to just short of wrap; five more writes then
    // land where 65536 further writes would: back at 0x0003.
    force dut1.wr_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut1.wr_cnt_q;
    for (int i = 0; i < 5; i++)
      xfer(1, 1, 8'h00, 32'h10 + 32'(i), 32'h0, 0, 2, "w2_wr_wrap");
    xfer(1, 0, 8'h00, 32'h0, 32'h00000014, 0, 2, "w2_rd_00");
    xfer(1, 0, 8'h10, 32'h0, 32'h00040003, 0, 2, "w2_status_wrap");

    // Instance 2, three wait states: normal write/read first.
    xfer(2, 1, 8'h08, 32'h11111111, 32'h0,        0, 3, "w3_wr_08");
    xfer(2, 0, 8'h08, 32'h0,        32'h11111111, 0, 3, "w3_rd_08");

    // Reset while PREADY is high on instance 0: outputs clear without an edge.
    sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0C;
    @(posedge clk); #1;
    penable = 1'b1; #1;
    check("rst_pre_pready", {31'd0, pready_m}, 32'd1);
    check("rst_pre_prdata", prdata_m, 32'hAAAAAAAA);
    hrst = 1'b1; #1;
    check("rst_async_pready", {31'd0, pready_m}, 32'd0);
    check("rst_async_prdata", prdata_m, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    hrst = 1'b0;
    @(posedge clk); #1;

    // Reset in the 2nd access cycle of a write on instance 2.
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h08; pwdata = 32'hDDDDDDDD;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_pre_pready", {31'd0, pready_m}, 32'd0);
    hrst = 1'b1; #1;
    check("rst_mid_pready", {31'd0, pready_m}, 32'd0);
    check("rst_mid_pslverr", {31'd0, pslverr_m}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    hrst = 1'b0;
    @(posedge clk); #1;

    xfer(2, 0, 8'h08, 32'h0, 32'h0, 0, 3, "w3_rd_08_after_rst");
    xfer(0, 0, 8'h0C, 32'h0, 32'h0, 0, 0, "w0_rd_0c_after_rst");
    xfer(1, 0, 8'h10, 32'h0, 32'h0, 0, 2, "w2_status_after_rst");

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
